// File: rtl/bsg_manycore_link_to_axil_pkg.sv
// Shared definitions for the manycore-link to AXI-lite bridge.
package bsg_manycore_link_to_axil_pkg;

    // Width of one host-side fifo packet.
    localparam int unsigned host_fifo_width_gp = 128;

    // Receive scheduler states.
    typedef enum logic {eIdle, eSend} rx_sched_state_e;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int unsigned safe_clog2(input int unsigned x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter: the request after the last granted one has highest priority.
module bsg_arb_round_robin
    import bsg_manycore_link_to_axil_pkg::*;
#(
    parameter int unsigned widths_p = 2,
    localparam int unsigned ptr_width_lp = safe_clog2(widths_p)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [widths_p-1:0] reqs_i,
    output logic [widths_p-1:0] grants_o,
    input  logic                yumi_i
);

    logic [ptr_width_lp-1:0] last_q;
    logic [ptr_width_lp-1:0] last_d;
    logic                    found;

    // Scan requests starting one past the last grant; first hit wins.
    always_comb begin
        grants_o = '0;
        last_d   = last_q;
        found    = 1'b0;
        for (int unsigned i = 1; i <= widths_p; i++) begin
            for (int unsigned j = 0; j < widths_p; j++) begin
                if (!found && reqs_i[j] && (j == (32'(last_q) + i) % widths_p)) begin
                    grants_o[j] = 1'b1;
                    last_d      = ptr_width_lp'(j);
                    found       = 1'b1;
                end
            end
        end
    end

    // Reset points at the last channel so channel 0 is favoured first.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_q <= ptr_width_lp'(widths_p - 1);
        end else if (yumi_i && |reqs_i) begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/bsg_manycore_link_to_axil_rx_sched.sv
// Round-robin scheduler that serializes host rx fifo packets onto one AXI-lite word stream.
module bsg_manycore_link_to_axil_rx_sched
    import bsg_manycore_link_to_axil_pkg::*;
#(
    parameter int unsigned axil_data_width_p = 32,
    parameter int unsigned num_ch_p = 2,
    localparam int unsigned ratio_lp = host_fifo_width_gp / axil_data_width_p,
    localparam int unsigned ch_width_lp = safe_clog2(num_ch_p),
    localparam int unsigned cnt_width_lp = safe_clog2(ratio_lp)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [num_ch_p*host_fifo_width_gp-1:0] fifo_data_i,
    input  logic [num_ch_p-1:0]                    fifo_v_i,
    output logic [num_ch_p-1:0]                    fifo_ready_o,
    output logic [axil_data_width_p-1:0]           axil_data_o,
    output logic                                   axil_v_o,
    input  logic                                   axil_ready_i,
    output logic [ch_width_lp-1:0]                 ch_o,
    output logic                                   last_o
);

    rx_sched_state_e               state_q;
    logic [cnt_width_lp-1:0]       cnt_q;
    logic [host_fifo_width_gp-1:0] pkt_q;
    logic [host_fifo_width_gp-1:0] pkt_sel;
    logic [ch_width_lp-1:0]        ch_q;
    logic [ch_width_lp-1:0]        grant_idx;
    logic [num_ch_p-1:0]           grants;
    logic                          any_v;
    logic                          yumi;
    logic                          last_word;

    assign any_v = |fifo_v_i;
    assign yumi  = (state_q == eIdle) & any_v;

    bsg_arb_round_robin #(
        .widths_p(num_ch_p)
    ) arb (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .reqs_i  (fifo_v_i),
        .grants_o(grants),
        .yumi_i  (yumi)
    );

    // Handshake only happens in eIdle; never acknowledge while in reset.
    assign fifo_ready_o = ((state_q == eIdle) && !reset_i) ? grants : '0;

    // Encode the one-hot grant and pick the granted channel's packet.
    always_comb begin
        grant_idx = '0;
        pkt_sel   = '0;
        for (int unsigned c = 0; c < num_ch_p; c++) begin
            if (grants[c]) begin
                grant_idx = ch_width_lp'(c);
                pkt_sel   = fifo_data_i[c*host_fifo_width_gp +: host_fifo_width_gp];
            end
        end
    end

    // Word select from the captured packet, least-significant word first.
    always_comb begin
        axil_data_o = '0;
        for (int unsigned i = 0; i < ratio_lp; i++) begin
            if (cnt_q == cnt_width_lp'(i)) begin
                axil_data_o = pkt_q[i*axil_data_width_p +: axil_data_width_p];
            end
        end
    end

    assign last_word = (cnt_q == cnt_width_lp'(ratio_lp - 1));
    assign axil_v_o  = !reset_i && (state_q == eSend);
    assign last_o    = axil_v_o && last_word;

    generate
        if (num_ch_p == 1) begin : g_single_ch
            assign ch_o = '0;
        end else begin : g_multi_ch
            assign ch_o = ch_q;
        end
    endgenerate

    // Capture a granted packet in eIdle, then stream its words in eSend.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= eIdle;
            cnt_q   <= '0;
            pkt_q   <= '0;
            ch_q    <= '0;
        end else begin
            case (state_q)
                eIdle: begin
                    if (any_v) begin
                        pkt_q   <= pkt_sel;
                        ch_q    <= grant_idx;
                        cnt_q   <= '0;
                        state_q <= eSend;
                    end
                end
                eSend: begin
                    if (axil_ready_i) begin
                        if (last_word) begin
                            cnt_q   <= '0;
                            state_q <= eIdle;
                        end else begin
                            cnt_q <= cnt_q + cnt_width_lp'(1);
                        end
                    end
                end
                default: state_q <= eIdle;
            endcase
        end
    end

endmodule
